matdet7_seq: RTL

- Iterative 7x7 determinant engine. It replaces the fully parallel seven-minor cofactor expansion with one shared 6x6 determinant datapath, visited once per column.
- A small FSM steps column j = 0..6 across row 0. Each cycle it selects minor M(0,j), multiplies its determinant by a[0][j], and adds or subtracts the product into an accumulator.
- Sits between a matrix producer and a result consumer. Both sides use valid/ready handshakes.
- Trades about 7x area for a 7-cycle latency.

---
 rtl/matdet7_seq_pkg.sv | 14 +
 rtl/matdet6.sv | 84 ++++++++
 rtl/matdet_minor_sel.sv | 21 ++
 rtl/matdet7_seq.sv | 89 ++++++++
 4 files changed

// File: rtl/matdet7_seq_pkg.sv
// Shared types and helpers for the iterative 7x7 determinant engine.
// Covers the FSM state encoding, matrix dimensions and element addressing.
package matdet7_seq_pkg;
  localparam int MAT_N   = 7;
  localparam int MINOR_N = 6;
  localparam int COL_W   = 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Bit offset of element (r,c) in a row-major MAT_N x MAT_N packed matrix.
  function automatic int elem_off(input int r, input int c, input int w);
    return (r * MAT_N + c) * w;
  endfunction
endpackage

// File: rtl/matdet6.sv
// Combinational 6x6 determinant modulo 2^DATA_WIDTH by cofactor expansion.
// Input packing: element (i,k) at slot 35-(i*6+k), so (0,0) sits in the MSBs.
module matdet6 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [36*DATA_WIDTH-1:0] minor,
  output logic [DATA_WIDTH-1:0]    det
);
  localparam int W = DATA_WIDTH;
  typedef logic [W-1:0] elem_t;

  // Internal order below is LSB-first row-major: element (i,k) at slot i*n+k.
  function automatic elem_t det2(input logic [4*W-1:0] m);
    elem_t p0, p1;
    p0 = m[0 +: W] * m[3*W +: W];
    p1 = m[W +: W] * m[2*W +: W];
    return p0 - p1;
  endfunction

  function automatic elem_t det3(input logic [9*W-1:0] m);
    logic [4*W-1:0] s;
    elem_t acc, t;
    acc = '0;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 2; k++)
          s[(i*2+k)*W +: W] = m[((i+1)*3 + ((k < j) ? k : k + 1))*W +: W];
      t   = m[j*W +: W] * det2(s);
      acc = (j % 2 == 1) ? acc - t : acc + t;
    end
    return acc;
  endfunction

  function automatic elem_t det4(input logic [16*W-1:0] m);
    logic [9*W-1:0] s;
    elem_t acc, t;
    acc = '0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 3; i++)
        for (int k = 0; k < 3; k++)
          s[(i*3+k)*W +: W] = m[((i+1)*4 + ((k < j) ? k : k + 1))*W +: W];
      t   = m[j*W +: W] * det3(s);
      acc = (j % 2 == 1) ? acc - t : acc + t;
    end
    return acc;
  endfunction

  function automatic elem_t det5(input logic [25*W-1:0] m);
    logic [16*W-1:0] s;
    elem_t acc, t;
    acc = '0;
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < 4; k++)
          s[(i*4+k)*W +: W] = m[((i+1)*5 + ((k < j) ? k : k + 1))*W +: W];
      t   = m[j*W +: W] * det4(s);
      acc = (j % 2 == 1) ? acc - t : acc + t;
    end
    return acc;
  endfunction

  function automatic elem_t det6f(input logic [36*W-1:0] m);
    logic [25*W-1:0] s;
    elem_t acc, t;
    acc = '0;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 5; i++)
        for (int k = 0; k < 5; k++)
          s[(i*5+k)*W +: W] = m[((i+1)*6 + ((k < j) ? k : k + 1))*W +: W];
      t   = m[j*W +: W] * det5(s);
      acc = (j % 2 == 1) ? acc - t : acc + t;
    end
    return acc;
  endfunction

  logic [36*W-1:0] flat;

  always_comb begin
    flat = '0;
    for (int n = 0; n < 36; n++)
      flat[n*W +: W] = minor[(35-n)*W +: W];
    det = det6f(flat);
  end
endmodule

// File: rtl/matdet_minor_sel.sv
// Builds minor M(0,col): rows 1..6 with column col dropped.
// The result is packed for matdet6, with minor element (0,0) in the top slot.
module matdet_minor_sel
  import matdet7_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [MAT_N*MAT_N*DATA_WIDTH-1:0]     mat,
  input  logic [COL_W-1:0]                      col,
  output logic [MINOR_N*MINOR_N*DATA_WIDTH-1:0] minor
);
  always_comb begin
    minor = '0;
    for (int i = 0; i < MINOR_N; i++) begin
      for (int k = 0; k < MINOR_N; k++) begin
        minor[(MINOR_N*MINOR_N-1-(i*MINOR_N+k))*DATA_WIDTH +: DATA_WIDTH] =
          mat[elem_off(i + 1, (k < int'(col)) ? k : k + 1, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end
endmodule

// File: rtl/matdet7_seq.sv
// Iterative 7x7 determinant: one shared 6x6 datapath visits each row-0 cofactor
// in turn, accumulating with alternating sign over 7 RUN cycles.
module matdet7_seq
  import matdet7_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = 49
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] a,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             det,
  output logic                              busy
);
  localparam int W = DATA_WIDTH;

  state_t                        state, state_nx;
  logic [COL_W-1:0]              col;
  logic [MATRIX_SIZE*W-1:0]      mat;
  logic [MINOR_N*MINOR_N*W-1:0]  minor;
  logic [W-1:0]                  minor_det, term, acc, acc_nx, det_r;

  matdet_minor_sel #(.DATA_WIDTH(W)) u_sel (
    .mat   (mat),
    .col   (col),
    .minor (minor)
  );

  matdet6 #(.DATA_WIDTH(W)) u_det6 (
    .minor (minor),
    .det   (minor_det)
  );

  // Laplace term for the current column; sign follows column parity.
  always_comb begin
    term = mat[elem_off(0, int'(col), W) +: W] * minor_det;
    if (col == '0)
      acc_nx = term;
    else if (col[0])
      acc_nx = acc - term;
    else
      acc_nx = acc + term;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)        state_nx = RUN;
      RUN:     if (col == 3'd6)     state_nx = DONE;
      DONE:    if (out_ready)       state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      col   <= '0;
      acc   <= '0;
      mat   <= '0;
      det_r <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mat <= a;
            col <= '0;
          end
        end
        RUN: begin
          acc <= acc_nx;
          col <= (col == 3'd6) ? '0 : col + 3'd1;
          if (col == 3'd6) det_r <= acc_nx;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign det       = det_r;
endmodule
